// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch / data) arbiter in front of a single
// downstream memory port. Exactly one transaction is in flight at a time.
//
// state | meaning
// IDLE  | no transaction; grant a requester combinationally and latch its fields
// REQ   | presenting latched request to memory until mem_req_ready
// WAIT  | waiting for mem_resp_valid or timeout expiry
// RESP  | one-cycle response pulse to the owning requester
module mem_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_resp_valid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_resp_err,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic                d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // Expiry is detected on the last WAIT cycle, i.e. when the count would
  // step onto TIMEOUT_CYC.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = data, 0 = fetch
  logic                last_q, last_d;     // last grant: 1 = data, 0 = fetch
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                grant_data;

  // Data wins when it is the only requester, or on a tie when fetch went last.
  assign grant_data = d_req_valid & (~i_req_valid | ~last_q);

  // Next-state, arbitration and capture logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid || d_req_valid) begin
          state_d = S_REQ;
          last_d  = grant_data;
          owner_d = grant_data;
          if (grant_data) begin
            d_req_ready = 1'b1;
            addr_d      = d_addr;
            wen_d       = d_wen;
            wdata_d     = d_wdata;
            wstrb_d     = d_wstrb;
          end else begin
            i_req_ready = 1'b1;
            addr_d      = i_addr;
            wen_d       = 1'b0;
            wdata_d     = '0;
            wstrb_d     = '0;
          end
        end
      end
      S_REQ: begin
        cnt_d = '0;
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and capture registers; reset aborts any transaction silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;

  assign i_resp_valid  = (state_q == S_RESP) && !owner_q;
  assign d_resp_valid  = (state_q == S_RESP) &&  owner_q;
  assign i_rdata       = rdata_q;
  assign d_rdata       = rdata_q;
  assign i_resp_err    = err_q;
  assign d_resp_err    = err_q;

  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short timeout (4 WAIT cycles).
module tb_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_valid, i_req_ready, i_resp_valid, i_resp_err;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req_valid, d_req_ready, d_wen, d_resp_valid, d_resp_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [SW-1:0] d_wstrb;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [SW-1:0] mem_wstrb;
  logic          busy;

  int n_cmp = 0;
  int n_mis = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_resp_valid(i_resp_valid), .i_rdata(i_rdata), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_wen(d_wen),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_resp_err(d_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req_valid = 1'b0; i_addr = '0;
    d_req_valid = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_i_ready", i_req_ready, 1'b0);
    chk1("rst_d_ready", d_req_ready, 1'b0);
    chk1("rst_mem_valid", mem_req_valid, 1'b0);
    chk1("rst_i_resp", i_resp_valid, 1'b0);
    chk1("rst_d_resp", d_resp_valid, 1'b0);
    step();
    rst = 1'b1;
  endtask

  logic exp_fetch [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    clear_inputs();
    #2;
    do_reset();

    // Single fetch at minimum latency.
    i_req_valid = 1'b1; i_addr = 64'h8000_0000;
    #1;
    chk1("f_i_ready", i_req_ready, 1'b1);
    chk1("f_d_ready", d_req_ready, 1'b0);
    step();                                   // REQ
    i_req_valid = 1'b0; i_addr = 64'h1234; mem_req_ready = 1'b1;
    chk1("f_mem_valid", mem_req_valid, 1'b1);
    chkw("f_mem_addr", mem_addr, 64'h8000_0000);
    chk1("f_mem_wen", mem_wen, 1'b0);
    chkw("f_mem_wstrb", 64'(mem_wstrb), 64'h0);
    chk1("f_busy", busy, 1'b1);
    step();                                   // WAIT
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h13;
    chk1("f_wait_mem_valid", mem_req_valid, 1'b0);
    step();                                   // RESP
    mem_resp_valid = 1'b0; mem_rdata = '0;
    chk1("f_i_resp", i_resp_valid, 1'b1);
    chkw("f_i_rdata", i_rdata, 64'h13);
    chk1("f_i_err", i_resp_err, 1'b0);
    chk1("f_d_resp", d_resp_valid, 1'b0);
    step();                                   // IDLE
    chk1("f_i_resp_done", i_resp_valid, 1'b0);
    chk1("f_idle_busy", busy, 1'b0);

    // Tie from reset: fetch, data, fetch, data.
    do_reset();
    i_req_valid = 1'b1; i_addr = 64'h100;
    d_req_valid = 1'b1; d_addr = 64'h200; d_wen = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'h55;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk1($sformatf("tie%0d_i_ready", g), i_req_ready, exp_fetch[g]);
      chk1($sformatf("tie%0d_d_ready", g), d_req_ready, ~exp_fetch[g]);
      step();                                 // REQ
      chk1($sformatf("tie%0d_req_i_ready", g), i_req_ready, 1'b0);
      chk1($sformatf("tie%0d_req_d_ready", g), d_req_ready, 1'b0);
      chkw($sformatf("tie%0d_addr", g), mem_addr, exp_fetch[g] ? 64'h100 : 64'h200);
      step();                                 // WAIT
      step();                                 // RESP
      chk1($sformatf("tie%0d_i_resp", g), i_resp_valid, exp_fetch[g]);
      chk1($sformatf("tie%0d_d_resp", g), d_resp_valid, ~exp_fetch[g]);
      step();                                 // IDLE
    end
    clear_inputs();

    // Store with back-pressure, then timeout with no response.
    d_req_valid = 1'b1; d_wen = 1'b1; d_addr = 64'h8000_1000;
    d_wdata = 64'hDEAD_BEEF; d_wstrb = 8'h0F;
    #1;
    chk1("st_d_ready", d_req_ready, 1'b1);
    chk1("st_i_ready", i_req_ready, 1'b0);
    step();                                   // REQ
    d_req_valid = 1'b0; d_wen = 1'b0; d_addr = 64'hFFFF; d_wdata = '0; d_wstrb = '0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_req_ready = 1'b1;
      chk1($sformatf("st%0d_mem_valid", k), mem_req_valid, 1'b1);
      chkw($sformatf("st%0d_addr", k), mem_addr, 64'h8000_1000);
      chk1($sformatf("st%0d_wen", k), mem_wen, 1'b1);
      chkw($sformatf("st%0d_wdata", k), mem_wdata, 64'hDEAD_BEEF);
      chkw($sformatf("st%0d_wstrb", k), 64'(mem_wstrb), 64'h0F);
      step();
    end
    mem_req_ready = 1'b0;                     // WAIT cycle 1
    chk1("to_mem_valid", mem_req_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("to%0d_no_resp", k), d_resp_valid, 1'b0);
      step();                                 // WAIT cycles 2..4
    end
    chk1("to4_busy", busy, 1'b1);
    chk1("to4_no_resp", d_resp_valid, 1'b0);
    step();                                   // RESP by timeout
    chk1("to_d_resp", d_resp_valid, 1'b1);
    chk1("to_d_err", d_resp_err, 1'b1);
    chkw("to_d_rdata", d_rdata, 64'h0);
    chk1("to_i_resp", i_resp_valid, 1'b0);
    step();                                   // IDLE

    // Stray response in IDLE is ignored.
    mem_resp_valid = 1'b1; mem_rdata = 64'h77;
    step();
    mem_resp_valid = 1'b0;
    chk1("stray_idle_busy", busy, 1'b0);
    chk1("stray_idle_d_resp", d_resp_valid, 1'b0);

    // Store whose response lands on the expiry cycle: response wins.
    d_req_valid = 1'b1; d_wen = 1'b1; d_addr = 64'h40; d_wdata = 64'h1; d_wstrb = 8'hFF;
    step();                                   // REQ
    clear_inputs();
    mem_req_ready = 1'b1;
    step();                                   // WAIT 1
    mem_req_ready = 1'b0;
    step();                                   // WAIT 2
    step();                                   // WAIT 3
    step();                                   // WAIT 4
    mem_resp_valid = 1'b1; mem_rdata = 64'hCAFE;
    step();                                   // RESP
    mem_resp_valid = 1'b0; mem_rdata = '0;
    chk1("race_d_resp", d_resp_valid, 1'b1);
    chk1("race_d_err", d_resp_err, 1'b0);
    chkw("race_d_rdata", d_rdata, 64'hCAFE);
    step();                                   // IDLE

    // Reset while waiting: silent abort.
    i_req_valid = 1'b1; i_addr = 64'h300;
    step();                                   // REQ
    i_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();                                   // WAIT
    mem_req_ready = 1'b0;
    chk1("rw_busy_pre", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk1("rw_busy_async", busy, 1'b0);
    chk1("rw_mem_valid", mem_req_valid, 1'b0);
    step();
    rst = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 64'h99;
    #1;
    chk1("rw_release_busy", busy, 1'b0);
    step();
    chk1("rw_post1_i_resp", i_resp_valid, 1'b0);
    chk1("rw_post1_busy", busy, 1'b0);
    step();
    mem_resp_valid = 1'b0;
    chk1("rw_post2_i_resp", i_resp_valid, 1'b0);
    chk1("rw_post2_d_resp", d_resp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, SHALL set width of all address ports.
REQ-002 Parameter DATA_W, default 64, SHALL set width of all data ports; strobe width SHALL be DATA_W/8.
REQ-003 Parameter TIMEOUT_CYC, default 255, SHALL set the response-wait limit in cycles; 0 SHALL disable timeout.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 i_req_valid  in  1  instruction-fetch read request; i_req_ready  out  1  fetch request accepted.
REQ-007 i_addr  in  ADDR_W  fetch address; i_resp_valid  out  1  one-cycle fetch response pulse; i_rdata  out  DATA_W; i_resp_err  out  1.
REQ-008 d_req_valid  in  1  data request; d_req_ready  out  1  data request accepted; d_wen  in  1  1 = store, 0 = load.
REQ-009 d_addr  in  ADDR_W; d_wdata  in  DATA_W; d_wstrb  in  DATA_W/8.
REQ-010 d_resp_valid  out  1  one-cycle data response pulse; d_rdata  out  DATA_W; d_resp_err  out  1.
REQ-011 mem_req_valid  out  1; mem_req_ready  in  1; mem_addr  out  ADDR_W; mem_wen  out  1; mem_wdata  out  DATA_W; mem_wstrb  out  DATA_W/8.
REQ-012 mem_resp_valid  in  1; mem_rdata  in  DATA_W  shared downstream memory port.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, REQ, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-015 IDLE: if any *_req_valid, SHALL assert exactly one *_req_ready combinationally in that cycle, latch the winner's addr/wen/wdata/wstrb and owner ID, and go to REQ.
REQ-016 Fetch requests SHALL latch mem_wen=0 and mem_wstrb=0 regardless of other inputs.
REQ-017 Arbitration: single valid requester wins; both valid -> winner is the requester NOT granted last; last-grant register resets to "data" (fetch wins first tie).
REQ-018 *_req_ready SHALL be 0 in REQ, WAIT, RESP; requesters hold valid and fields stable until ready.
REQ-019 REQ: mem_req_valid=1 with latched fields; on mem_req_ready=1 go to WAIT; mem_req_valid SHALL be 0 in all other states.
REQ-020 WAIT: on mem_resp_valid=1 capture mem_rdata, err=0, go to RESP.
REQ-021 WAIT: timeout counter SHALL clear on entry and increment each WAIT cycle without response; when counter reaches TIMEOUT_CYC (TIMEOUT_CYC!=0) go to RESP with err=1, rdata=0.
REQ-022 mem_resp_valid and timeout expiry in the same cycle: response SHALL win, err=0.
REQ-023 RESP: owner's *_resp_valid=1 for exactly one cycle with captured rdata/err; other requester's resp_valid=0; next state IDLE.
REQ-024 Store responses SHALL still pass mem_rdata through unchanged; requester ignores it.
REQ-025 mem_resp_valid in IDLE, REQ or RESP SHALL be ignored, no state change.
REQ-026 Minimum latency: accept at cycle N, mem_req_ready at N+1, mem_resp_valid at N+2 -> *_resp_valid at N+3; next grant earliest N+4.
REQ-027 Counter SHALL be wide enough to hold TIMEOUT_CYC without wrap.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, last-grant=data, counter=0, captured data/err=0, all *_ready, *_resp_valid, mem_req_valid, busy = 0.
REQ-029 Reset mid-transaction SHALL abort silently: no response pulse issued after release; first cycle after release is IDLE.

Verification
REQ-030 Single fetch: i_req_valid, i_addr=0x80000000, mem_req_ready immediately, mem_resp_valid next cycle with mem_rdata=0x00000013 -> i_resp_valid one cycle later, i_rdata=0x13, i_resp_err=0, d_resp_valid stays 0.
REQ-031 Tie: both valid continuously from reset -> grant order fetch, data, fetch, data; each ready one cycle.
REQ-032 Store: d_wen=1, d_addr=0x80001000, d_wdata=0xDEADBEEF, d_wstrb=0x0F, mem_req_ready held 0 for 3 cycles -> mem_req_valid held 4 cycles with fields stable, mem_wen=1.
REQ-033 Timeout: TIMEOUT_CYC=4, no mem_resp_valid -> d_resp_valid with d_resp_err=1, d_rdata=0 after 4 WAIT cycles; response+expiry same cycle -> err=0.
REQ-034 Reset in WAIT: drive rst=0 for one cycle -> busy=0 immediately, no resp pulse afterwards, stray mem_resp_valid ignored.
